// File: rtl/idecode.sv
// PDP-11 instruction pre-decoder with a two-entry queue of decoded instructions.
// Words are classified and split into fields on entry; the head entry drives the outputs.
module idecode (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  input  logic [15:0] in_instr,
  output logic        in_ready,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [9:0]  op,
  output logic [2:0]  cls,
  output logic [2:0]  src_mode,
  output logic [2:0]  src_reg,
  output logic [2:0]  dst_mode,
  output logic [2:0]  dst_reg,
  output logic        byte_op,
  output logic        store,
  output logic [7:0]  offset
);

  localparam logic [2:0] CLS_SINGLE = 3'd0;
  localparam logic [2:0] CLS_DOUBLE = 3'd1;
  localparam logic [2:0] CLS_REGSRC = 3'd2;
  localparam logic [2:0] CLS_BRANCH = 3'd3;
  localparam logic [2:0] CLS_OTHER  = 3'd4;

  typedef struct packed {
    logic [9:0] op;
    logic [2:0] cls;
    logic [2:0] src_mode;
    logic [2:0] src_reg;
    logic [2:0] dst_mode;
    logic [2:0] dst_reg;
    logic       byte_op;
    logic       store;
    logic [7:0] offset;
  } entry_t;

  localparam entry_t ENTRY_RST = {10'd0, CLS_OTHER, 12'd0, 1'b0, 1'b0, 8'd0};

  // Classes are tested in precedence order, so overlapping encodings resolve to the first match.
  function automatic entry_t decode(input logic [15:0] i);
    entry_t e;
    logic   is_double;
    logic   is_regsrc;
    logic   is_branch;
    logic   is_single;
    logic   no_store;
    e          = ENTRY_RST;
    e.op       = i[15:6];
    e.offset   = i[7:0];
    is_double  = (i[14:12] != 3'o0) && (i[14:12] != 3'o7);
    is_regsrc  = (i[15:12] == 4'o07);
    is_branch  = (i[14:11] == 4'b0000) && ((i[10:8] != 3'o0) || i[15]);
    is_single  = (i[14:11] == 4'b0001) || (i[15:6] == 10'o0003);
    no_store   = (i[14:12] == 3'o2) || (i[14:12] == 3'o3) || (i[14:6] == 9'o057);
    if (is_double) begin
      e.cls      = CLS_DOUBLE;
      e.src_mode = i[11:9];
      e.src_reg  = i[8:6];
      e.dst_mode = i[5:3];
      e.dst_reg  = i[2:0];
      e.byte_op  = i[15] && (i[15:12] != 4'o16);
      e.store    = !no_store;
    end else if (is_regsrc) begin
      e.cls      = CLS_REGSRC;
      e.src_reg  = i[8:6];
      e.dst_mode = i[5:3];
      e.dst_reg  = i[2:0];
      e.store    = 1'b1;
    end else if (is_branch) begin
      e.cls      = CLS_BRANCH;
    end else if (is_single) begin
      e.cls      = CLS_SINGLE;
      e.dst_mode = i[5:3];
      e.dst_reg  = i[2:0];
      e.byte_op  = i[15];
      e.store    = !no_store;
    end else begin
      e.cls      = CLS_OTHER;
    end
    return e;
  endfunction

  entry_t     mem_r [2];
  logic [1:0] cnt_r;
  logic       wr_ptr_r;
  logic       rd_ptr_r;
  logic       push_s;
  logic       pop_s;
  entry_t     head_s;

  assign in_ready  = (cnt_r != 2'd2);
  assign out_valid = (cnt_r != 2'd0);
  assign push_s    = in_valid && in_ready;
  assign pop_s     = out_valid && out_ready;
  assign head_s    = mem_r[rd_ptr_r];

  // Queue storage, pointers and occupancy; reset beats flush, flush beats push/pop.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mem_r[0] <= ENTRY_RST;
      mem_r[1] <= ENTRY_RST;
      cnt_r    <= 2'd0;
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
    end else if (flush) begin
      cnt_r    <= 2'd0;
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= decode(in_instr);
        wr_ptr_r        <= ~wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
      case ({push_s, pop_s})
        2'b10:   cnt_r <= cnt_r + 2'd1;
        2'b01:   cnt_r <= cnt_r - 2'd1;
        default: cnt_r <= cnt_r;
      endcase
    end
  end

  assign op       = head_s.op;
  assign cls      = head_s.cls;
  assign src_mode = head_s.src_mode;
  assign src_reg  = head_s.src_reg;
  assign dst_mode = head_s.dst_mode;
  assign dst_reg  = head_s.dst_reg;
  assign byte_op  = head_s.byte_op;
  assign store    = head_s.store;
  assign offset   = head_s.offset;

endmodule

// File: tb/tb_idecode.sv
// Directed bench for idecode: decode table, backpressure, streaming, flush and reset.
module tb_idecode;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic [15:0] in_instr;
  logic        in_ready;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [9:0]  op;
  logic [2:0]  cls;
  logic [2:0]  src_mode;
  logic [2:0]  src_reg;
  logic [2:0]  dst_mode;
  logic [2:0]  dst_reg;
  logic        byte_op;
  logic        store;
  logic [7:0]  offset;

  int checks = 0;
  int errors = 0;

  idecode dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_instr(in_instr),
    .in_ready(in_ready), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .op(op), .cls(cls), .src_mode(src_mode), .src_reg(src_reg),
    .dst_mode(dst_mode), .dst_reg(dst_reg), .byte_op(byte_op), .store(store),
    .offset(offset)
  );

  always #5 clk = ~clk;

  localparam int NV = 14;
  localparam logic [15:0] VW [NV] = '{16'o010203, 16'o160102, 16'o120102, 16'o001403,
    16'o005713, 16'o000303, 16'o074203, 16'o100012, 16'o000000, 16'o170000,
    16'o105003, 16'o105703, 16'o132345, 16'o062716};
  localparam logic [9:0] VOP [NV] = '{10'o0102, 10'o1601, 10'o1201, 10'o0014,
    10'o0057, 10'o0003, 10'o0742, 10'o1000, 10'o0000, 10'o1700,
    10'o1050, 10'o1057, 10'o1323, 10'o0627};
  localparam logic [2:0] VCLS [NV] = '{3'd1, 3'd1, 3'd1, 3'd3, 3'd0, 3'd0, 3'd2, 3'd3, 3'd4, 3'd4, 3'd0, 3'd0, 3'd1, 3'd1};
  localparam logic [2:0] VSM  [NV] = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd2, 3'd2};
  localparam logic [2:0] VSR  [NV] = '{3'd2, 3'd1, 3'd1, 3'd0, 3'd0, 3'd0, 3'd2, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd3, 3'd7};
  localparam logic [2:0] VDM  [NV] = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd4, 3'd1};
  localparam logic [2:0] VDR  [NV] = '{3'd3, 3'd2, 3'd2, 3'd0, 3'd3, 3'd3, 3'd3, 3'd0, 3'd0, 3'd0, 3'd3, 3'd3, 3'd5, 3'd6};
  localparam logic       VB   [NV] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
  localparam logic       VST  [NV] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
  localparam logic [7:0] VOFF [NV] = '{8'h83, 8'h42, 8'h42, 8'h03, 8'hCB, 8'hC3, 8'h83,
    8'h0A, 8'h00, 8'h00, 8'h03, 8'hC3, 8'hE5, 8'hCE};

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 'o%0o, expected 'o%0o", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic [15:0] w);
    in_valid = 1'b1;
    in_instr = w;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic pop_one();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic check_vec(input int v);
    check_eq($sformatf("v%0d out_valid", v), 32'(out_valid), 32'd1);
    check_eq($sformatf("v%0d op", v),       32'(op),       32'(VOP[v]));
    check_eq($sformatf("v%0d cls", v),      32'(cls),      32'(VCLS[v]));
    check_eq($sformatf("v%0d src_mode", v), 32'(src_mode), 32'(VSM[v]));
    check_eq($sformatf("v%0d src_reg", v),  32'(src_reg),  32'(VSR[v]));
    check_eq($sformatf("v%0d dst_mode", v), 32'(dst_mode), 32'(VDM[v]));
    check_eq($sformatf("v%0d dst_reg", v),  32'(dst_reg),  32'(VDR[v]));
    check_eq($sformatf("v%0d byte_op", v),  32'(byte_op),  32'(VB[v]));
    check_eq($sformatf("v%0d store", v),    32'(store),    32'(VST[v]));
    check_eq($sformatf("v%0d offset", v),   32'(offset),   32'(VOFF[v]));
  endtask

  initial begin
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_instr  = 16'd0;
    flush     = 1'b0;
    out_ready = 1'b0;
    repeat (3) tick();
    check_eq("rst out_valid", 32'(out_valid), 32'd0);
    check_eq("rst in_ready",  32'(in_ready),  32'd1);
    check_eq("rst op",        32'(op),        32'd0);
    check_eq("rst cls",       32'(cls),       32'd4);
    check_eq("rst store",     32'(store),     32'd0);

    // first edge after reset release accepts a word
    reset_n = 1'b1;
    push_one(VW[0]);
    check_vec(0);
    pop_one();
    check_eq("empty after pop", 32'(out_valid), 32'd0);

    for (int v = 1; v < NV; v++) begin
      push_one(VW[v]);
      check_vec(v);
      pop_one();
    end

    // backpressure: three pushes with out_ready low
    in_valid = 1'b1;
    in_instr = VW[0];
    tick();
    check_eq("bp ready after 1", 32'(in_ready), 32'd1);
    in_instr = VW[1];
    tick();
    check_eq("bp ready after 2", 32'(in_ready), 32'd0);
    in_instr = VW[2];
    tick();
    check_eq("bp held ready", 32'(in_ready), 32'd0);
    check_eq("bp head 1 op",  32'(op), 32'(VOP[0]));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_eq("bp head 2 op",    32'(op),      32'(VOP[1]));
    check_eq("bp head 2 byte",  32'(byte_op), 32'd0);
    check_eq("bp head 2 store", 32'(store),   32'd1);
    check_eq("bp ready after pop", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    check_eq("bp 3rd accepted", 32'(in_ready), 32'd0);
    check_eq("bp head still 2", 32'(op), 32'(VOP[1]));
    pop_one();
    check_eq("bp head 3 op",    32'(op),      32'(VOP[2]));
    check_eq("bp head 3 byte",  32'(byte_op), 32'd1);
    check_eq("bp head 3 store", 32'(store),   32'd0);
    pop_one();
    check_eq("bp drained", 32'(out_valid), 32'd0);

    // streaming at occupancy 1
    push_one(16'o010000);
    for (int k = 1; k <= 10; k++) begin
      check_eq($sformatf("stream head %0d", k - 1), 32'(op), 32'(10'o0100 + 10'(k - 1)));
      in_valid  = 1'b1;
      in_instr  = 16'o010000 + 16'(k) * 16'd64;
      out_ready = 1'b1;
      tick();
      check_eq($sformatf("stream valid %0d", k), 32'(out_valid), 32'd1);
      check_eq($sformatf("stream ready %0d", k), 32'(in_ready),  32'd1);
    end
    in_valid = 1'b0;
    check_eq("stream last", 32'(op), 32'(10'o0112));
    tick();
    out_ready = 1'b0;
    check_eq("stream drained", 32'(out_valid), 32'd0);

    // flush with full queue and a push
    push_one(VW[0]);
    push_one(VW[1]);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_instr = VW[2];
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    check_eq("flush out_valid", 32'(out_valid), 32'd0);
    check_eq("flush in_ready",  32'(in_ready),  32'd1);
    push_one(VW[3]);
    check_eq("post flush op", 32'(op), 32'(VOP[3]));
    // flush together with a pop at occupancy 1
    flush     = 1'b1;
    out_ready = 1'b1;
    tick();
    flush     = 1'b0;
    out_ready = 1'b0;
    check_eq("flush+pop out_valid", 32'(out_valid), 32'd0);
    check_eq("flush+pop in_ready",  32'(in_ready),  32'd1);
    push_one(VW[4]);
    check_eq("post flush+pop op", 32'(op), 32'(VOP[4]));
    pop_one();

    // reset with full queue and a push
    push_one(VW[5]);
    push_one(VW[6]);
    reset_n  = 1'b0;
    in_valid = 1'b1;
    in_instr = VW[7];
    tick();
    in_valid = 1'b0;
    reset_n  = 1'b1;
    check_eq("mid rst out_valid", 32'(out_valid), 32'd0);
    check_eq("mid rst in_ready",  32'(in_ready),  32'd1);
    check_eq("mid rst op",        32'(op),        32'd0);
    check_eq("mid rst cls",       32'(cls),       32'd4);
    push_one(VW[12]);
    check_eq("post rst op", 32'(op), 32'(VOP[12]));
    pop_one();
    check_eq("final empty", 32'(out_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
